// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: commit path has priority, long-latency results
// are written directly or buffered in an in-order FIFO, with a per-register pending scoreboard.
module reg_write_arbiter #(
    parameter int DEPTH          = 2,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      commitWriteEnable,
    input  logic [REG_ADDR_WIDTH-1:0] commitWriteAddr,
    input  logic [DATA_WIDTH-1:0]     commitWriteValue,
    input  logic                      issueValid,
    input  logic [REG_ADDR_WIDTH-1:0] issueAddr,
    input  logic                      lluValid,
    input  logic [REG_ADDR_WIDTH-1:0] lluAddr,
    input  logic [DATA_WIDTH-1:0]     lluValue,
    output logic                      lluReady,
    input  logic [REG_ADDR_WIDTH-1:0] queryAddr1,
    input  logic [REG_ADDR_WIDTH-1:0] queryAddr2,
    output logic                      busy1,
    output logic                      busy2,
    output logic                      regWriteEnable,
    output logic [REG_ADDR_WIDTH-1:0] regWriteAddr,
    output logic [DATA_WIDTH-1:0]     regWriteValue
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int NREG  = 1 << REG_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [NREG-1:0]           pending;
    logic [NREG-1:0]           pending_nxt;
    logic [REG_ADDR_WIDTH-1:0] fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data [DEPTH];
    logic [PTR_W-1:0]          head;
    logic [PTR_W-1:0]          tail;
    logic [CNT_W-1:0]          count;

    logic fifo_empty;
    logic port_valid;
    logic pop;
    logic bypass;
    logic push;

    assign fifo_empty = (count == '0);
    // Full is judged on the registered count only, so a pop never frees a slot in the same cycle.
    assign lluReady   = (count < DEPTH_C) && !flush;
    assign push       = lluValid && lluReady && !bypass;

    always_comb begin
        pop           = 1'b0;
        bypass        = 1'b0;
        port_valid    = 1'b0;
        regWriteAddr  = commitWriteAddr;
        regWriteValue = commitWriteValue;
        if (commitWriteEnable) begin
            port_valid = 1'b1;
        end else if (!fifo_empty) begin
            regWriteAddr  = fifo_addr[head];
            regWriteValue = fifo_data[head];
            pop           = !flush;
            port_valid    = !flush;
        end else if (lluValid) begin
            regWriteAddr  = lluAddr;
            regWriteValue = lluValue;
            bypass        = lluReady;
            port_valid    = lluReady;
        end
        // x0 is hardwired: the slot is consumed but nothing is written.
        regWriteEnable = port_valid && (regWriteAddr != '0);
    end

    always_comb begin
        pending_nxt = pending;
        if (pop || bypass) begin
            pending_nxt[regWriteAddr] = 1'b0;
        end
        if (issueValid && (issueAddr != '0)) begin
            pending_nxt[issueAddr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    assign busy1 = pending[queryAddr1];
    assign busy2 = pending[queryAddr2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else if (flush) begin
            pending <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            pending <= pending_nxt;
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= lluAddr;
            fifo_data[tail] <= lluValue;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: bypass, buffering, full FIFO, scoreboard, flush, async reset.
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        commitWriteEnable;
    logic [4:0]  commitWriteAddr;
    logic [31:0] commitWriteValue;
    logic        issueValid;
    logic [4:0]  issueAddr;
    logic        lluValid;
    logic [4:0]  lluAddr;
    logic [31:0] lluValue;
    logic        lluReady;
    logic [4:0]  queryAddr1;
    logic [4:0]  queryAddr2;
    logic        busy1;
    logic        busy2;
    logic        regWriteEnable;
    logic [4:0]  regWriteAddr;
    logic [31:0] regWriteValue;

    int vectors = 0;
    int miscompares = 0;

    reg_write_arbiter #(.DEPTH(2), .REG_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .commitWriteEnable(commitWriteEnable), .commitWriteAddr(commitWriteAddr),
        .commitWriteValue(commitWriteValue),
        .issueValid(issueValid), .issueAddr(issueAddr),
        .lluValid(lluValid), .lluAddr(lluAddr), .lluValue(lluValue), .lluReady(lluReady),
        .queryAddr1(queryAddr1), .queryAddr2(queryAddr2), .busy1(busy1), .busy2(busy2),
        .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr), .regWriteValue(regWriteValue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; commitWriteEnable = 0; commitWriteAddr = 0; commitWriteValue = 0;
        issueValid = 0; issueAddr = 0; lluValid = 0; lluAddr = 0; lluValue = 0;
    endtask

    task automatic issue(input logic [4:0] a);
        issueValid = 1; issueAddr = a;
        step();
        issueValid = 0; issueAddr = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); queryAddr1 = 0; queryAddr2 = 0;
        #1;
        vectors++; if (lluReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", lluReady); end
        vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", regWriteEnable); end
        vectors++; if ({busy1, busy2} !== 2'b00) begin miscompares++; $display("FAIL reset_busy: got %b want 00", {busy1, busy2}); end
        repeat (2) step();
        rst = 0;
        step();
    endtask

    task automatic test_idle_bypass();
        issue(5'd5);
        queryAddr1 = 5;
        lluValid = 1; lluAddr = 5; lluValue = 32'hDEADBEEF;
        #1;
        vectors++; if (regWriteEnable !== 1'b1) begin miscompares++; $display("FAIL bypass_we: got %b want 1", regWriteEnable); end
        vectors++; if (regWriteAddr !== 5'd5) begin miscompares++; $display("FAIL bypass_addr: got %0d want 5", regWriteAddr); end
        vectors++; if (regWriteValue !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bypass_value: got %h want deadbeef", regWriteValue); end
        vectors++; if (lluReady !== 1'b1) begin miscompares++; $display("FAIL bypass_ready: got %b want 1", lluReady); end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL bypass_busy_same_cycle: got %b want 1", busy1); end
        step();
        idle_inputs();
        #1;
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL bypass_busy_cleared: got %b want 0", busy1); end
        vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL bypass_no_repeat: got %b want 0", regWriteEnable); end
    endtask

    task automatic test_conflict();
        issue(5'd7);
        queryAddr1 = 7;
        lluValid = 1; lluAddr = 7; lluValue = 32'h11;
        commitWriteEnable = 1; commitWriteAddr = 3; commitWriteValue = 32'h22;
        #1;
        vectors++; if ({regWriteEnable, regWriteAddr, regWriteValue} !== {1'b1, 5'd3, 32'h22}) begin
            miscompares++; $display("FAIL conflict_c0_write: got %b/%0d/%h want 1/3/22", regWriteEnable, regWriteAddr, regWriteValue); end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL conflict_c0_busy: got %b want 1", busy1); end
        vectors++; if (lluReady !== 1'b1) begin miscompares++; $display("FAIL conflict_c0_ready: got %b want 1", lluReady); end
        step();
        idle_inputs();
        #1;
        vectors++; if ({regWriteEnable, regWriteAddr, regWriteValue} !== {1'b1, 5'd7, 32'h11}) begin
            miscompares++; $display("FAIL conflict_c1_write: got %b/%0d/%h want 1/7/11", regWriteEnable, regWriteAddr, regWriteValue); end
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL conflict_c1_busy: got %b want 1", busy1); end
        step();
        #1;
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL conflict_c2_busy: got %b want 0", busy1); end
        vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL conflict_c2_we: got %b want 0", regWriteEnable); end
    endtask

    task automatic test_fifo_full();
        logic [2:0]  exp_ready;
        logic [4:0]  exp_addr [3];
        logic [31:0] exp_val [3];
        exp_ready = 3'b011;
        exp_addr[0] = 8;  exp_addr[1] = 9;  exp_addr[2] = 10;
        exp_val[0] = 1;   exp_val[1] = 2;   exp_val[2] = 3;
        issue(5'd8); issue(5'd9); issue(5'd10);
        queryAddr1 = 10;
        commitWriteEnable = 1; commitWriteAddr = 1;
        for (int i = 0; i < 3; i++) begin
            commitWriteValue = 32'h100 + i;
            lluValid = 1; lluAddr = exp_addr[i]; lluValue = exp_val[i];
            if (i == 2) lluValid = 1;
            #1;
            vectors++; if (lluReady !== exp_ready[i]) begin miscompares++; $display("FAIL full_ready_%0d: got %b want %b", i, lluReady, exp_ready[i]); end
            vectors++; if ({regWriteEnable, regWriteAddr, regWriteValue} !== {1'b1, 5'd1, 32'h100 + i}) begin
                miscompares++; $display("FAIL full_commit_%0d: got %b/%0d/%h", i, regWriteEnable, regWriteAddr, regWriteValue); end
            if (i < 2) step();
        end
        step();
        commitWriteEnable = 0; commitWriteAddr = 0; commitWriteValue = 0;
        #1;
        vectors++; if (lluReady !== 1'b0) begin miscompares++; $display("FAIL full_pop_no_ready: got %b want 0", lluReady); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) #1;
            vectors++; if ({regWriteEnable, regWriteAddr, regWriteValue} !== {1'b1, exp_addr[i], exp_val[i]}) begin
                miscompares++; $display("FAIL full_drain_%0d: got %b/%0d/%h want 1/%0d/%h", i, regWriteEnable, regWriteAddr, regWriteValue, exp_addr[i], exp_val[i]); end
            vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL full_busy10_%0d: got %b want 1", i, busy1); end
            step();
            if (i == 1) begin lluValid = 0; lluAddr = 0; lluValue = 0; end
        end
        #1;
        vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL full_drained_we: got %b want 0", regWriteEnable); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL full_busy10_clear: got %b want 0", busy1); end
        vectors++; if (lluReady !== 1'b1) begin miscompares++; $display("FAIL full_ready_after: got %b want 1", lluReady); end
    endtask

    task automatic test_scoreboard();
        issue(5'd4); issue(5'd6);
        queryAddr1 = 4; queryAddr2 = 6;
        #1;
        vectors++; if ({busy1, busy2} !== 2'b11) begin miscompares++; $display("FAIL sb_both_busy: got %b want 11", {busy1, busy2}); end
        issueValid = 1; issueAddr = 12;
        lluValid = 1; lluAddr = 4; lluValue = 32'h44;
        #1;
        vectors++; if ({regWriteEnable, regWriteAddr} !== {1'b1, 5'd4}) begin miscompares++; $display("FAIL sb_write4: got %b/%0d want 1/4", regWriteEnable, regWriteAddr); end
        step();
        idle_inputs();
        queryAddr1 = 4; queryAddr2 = 12;
        #1;
        vectors++; if ({busy1, busy2} !== 2'b01) begin miscompares++; $display("FAIL sb_set12_clear4: got %b want 01", {busy1, busy2}); end
        issue(5'd0);
        queryAddr1 = 0;
        #1;
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL sb_x0_busy: got %b want 0", busy1); end
        // A result to x0 is accepted but not written.
        lluValid = 1; lluAddr = 0; lluValue = 32'hFF;
        #1;
        vectors++; if ({regWriteEnable, lluReady} !== 2'b01) begin miscompares++; $display("FAIL sb_x0_llu: got we/ready %b want 01", {regWriteEnable, lluReady}); end
        idle_inputs();
        commitWriteEnable = 1; commitWriteAddr = 0; commitWriteValue = 32'h77;
        #1;
        vectors++; if ({regWriteEnable, regWriteAddr} !== {1'b0, 5'd0}) begin miscompares++; $display("FAIL sb_x0_commit: got %b/%0d want 0/0", regWriteEnable, regWriteAddr); end
        step();
        idle_inputs();
    endtask

    task automatic test_flush();
        issue(5'd8); issue(5'd9);
        commitWriteEnable = 1; commitWriteAddr = 1; commitWriteValue = 32'h1;
        lluValid = 1; lluAddr = 8; lluValue = 32'h80;
        step();
        lluAddr = 9; lluValue = 32'h90;
        step();
        flush = 1; commitWriteAddr = 2; commitWriteValue = 32'h5;
        lluAddr = 11; lluValue = 32'hB0;
        issueValid = 1; issueAddr = 13;
        #1;
        vectors++; if ({regWriteEnable, regWriteAddr, regWriteValue} !== {1'b1, 5'd2, 32'h5}) begin
            miscompares++; $display("FAIL flush_commit: got %b/%0d/%h want 1/2/5", regWriteEnable, regWriteAddr, regWriteValue); end
        vectors++; if (lluReady !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", lluReady); end
        step();
        idle_inputs();
        queryAddr1 = 8; queryAddr2 = 9;
        #1;
        vectors++; if ({busy1, busy2} !== 2'b00) begin miscompares++; $display("FAIL flush_busy89: got %b want 00", {busy1, busy2}); end
        queryAddr1 = 13; queryAddr2 = 12;
        #1;
        vectors++; if ({busy1, busy2} !== 2'b00) begin miscompares++; $display("FAIL flush_busy13_12: got %b want 00", {busy1, busy2}); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL flush_no_write_%0d: got %b want 0", i, regWriteEnable); end
            step();
        end
    endtask

    task automatic test_async_reset();
        issue(5'd14);
        queryAddr1 = 14;
        commitWriteEnable = 1; commitWriteAddr = 1; commitWriteValue = 32'h1;
        lluValid = 1; lluAddr = 14; lluValue = 32'hE;
        step();
        idle_inputs();
        #1;
        vectors++; if ({regWriteEnable, regWriteAddr} !== {1'b1, 5'd14}) begin miscompares++; $display("FAIL arst_pre_write: got %b/%0d want 1/14", regWriteEnable, regWriteAddr); end
        #1 rst = 1;
        #1;
        vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL arst_we: got %b want 0", regWriteEnable); end
        vectors++; if (lluReady !== 1'b1) begin miscompares++; $display("FAIL arst_ready: got %b want 1", lluReady); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL arst_busy: got %b want 0", busy1); end
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (regWriteEnable !== 1'b0) begin miscompares++; $display("FAIL arst_no_write_%0d: got %b want 0", i, regWriteEnable); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_idle_bypass();
        test_conflict();
        test_fifo_full();
        test_scoreboard();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
